// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out has priority, CPU is guaranteed service via a starvation guard.
// Optional stall counter enabled by defining VRAM_ARB_PERF_EN.
module vram_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ARB_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [15:0]       cpu_stall_cnt
`endif
);

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_DISP = 2'd1;
    localparam logic [1:0] TAG_CPU  = 2'd2;
    localparam logic [7:0] SL8      = 8'(STARVE_LIMIT);

    logic              r_disp_pend;
    logic [ADDR_W-1:0] r_disp_pend_addr;
    logic [7:0]        r_starve_cnt;
    logic [1:0]        r_tag;
    logic              r_tag_we;
    logic              r_cpu_done;
    logic [DATA_W-1:0] r_cpu_rdata;

    logic              w_d_cand;
    logic              w_c_cand;
    logic              w_cpu_win;
    logic              w_disp_win;
    logic [ADDR_W-1:0] w_disp_addr;
    logic [DATA_W-1:0] w_cpu_resp;

    // Candidates are masked by reset so the RAM port stays quiet while RSTn is low.
    assign w_d_cand    = RSTn & (disp_req | r_disp_pend);
    assign w_c_cand    = RSTn & cpu_req & ~r_cpu_done;
    assign w_cpu_win   = w_c_cand & (~w_d_cand | (r_starve_cnt >= SL8));
    assign w_disp_win  = w_d_cand & ~w_cpu_win;
    assign w_disp_addr = disp_req ? disp_addr : r_disp_pend_addr;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (w_cpu_win) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_we ? cpu_wdata : '0;
        end else if (w_disp_win) begin
            ram_en   = 1'b1;
            ram_addr = w_disp_addr;
        end
    end

    // A direct disp_req that loses (or overflows) always replaces the pending entry.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_disp_pend      <= 1'b0;
            r_disp_pend_addr <= '0;
        end else if (w_disp_win) begin
            r_disp_pend <= 1'b0;
        end else if (disp_req) begin
            r_disp_pend      <= 1'b1;
            r_disp_pend_addr <= disp_addr;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_starve_cnt <= '0;
        end else if (w_cpu_win || !w_c_cand) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt < SL8) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_tag    <= TAG_NONE;
            r_tag_we <= 1'b0;
        end else if (w_cpu_win) begin
            r_tag    <= TAG_CPU;
            r_tag_we <= cpu_we;
        end else if (w_disp_win) begin
            r_tag    <= TAG_DISP;
            r_tag_we <= 1'b0;
        end else begin
            r_tag    <= TAG_NONE;
            r_tag_we <= 1'b0;
        end
    end

    // cpu_done masks the held request between issue and its ready pulse.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_cpu_done <= 1'b0;
        end else if (w_cpu_win) begin
            r_cpu_done <= 1'b1;
        end else if (r_tag == TAG_CPU) begin
            r_cpu_done <= 1'b0;
        end
    end

    assign w_cpu_resp = r_tag_we ? '0 : ram_rdata;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_cpu_rdata <= '0;
        end else if (r_tag == TAG_CPU) begin
            r_cpu_rdata <= w_cpu_resp;
        end
    end

    assign disp_rvalid = (r_tag == TAG_DISP);
    assign disp_rdata  = disp_rvalid ? ram_rdata : '0;
    assign cpu_ready   = (r_tag == TAG_CPU);
    assign cpu_rdata   = cpu_ready ? w_cpu_resp : r_cpu_rdata;

`ifdef VRAM_ARB_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_stall_cnt <= '0;
        end else if (perf_clr) begin
            r_stall_cnt <= '0;
        end else if (w_c_cand && w_disp_win && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign cpu_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, transaction-level reference model compared every cycle, directed scenarios.
// Define VRAM_ARB_PERF_EN to also exercise the stall counter.
module tb_vram_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int SL = 8;

    logic          clk = 1'b0;
    logic          RSTn;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic [DW-1:0] cpu_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
`ifdef VRAM_ARB_PERF_EN
    logic          perf_clr;
    logic [15:0]   cpu_stall_cnt;
`endif

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .RSTn(RSTn),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
`ifdef VRAM_ARB_PERF_EN
        , .perf_clr(perf_clr), .cpu_stall_cnt(cpu_stall_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- RAM macro model ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];

    initial ram_rdata = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cnt_ready = 0;
    int cnt_wr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: responses are a scoreboard of data due one cycle after issue.
    logic [DW-1:0] exp_disp_q[$];
    logic [DW-1:0] exp_cpu_q[$];
    logic          m_pend;
    logic [AW-1:0] m_pend_addr;
    int            m_wait;
    logic          m_cpu_busy;
    logic [DW-1:0] m_cpu_hold;
    int            m_stall;
    logic          d_want, c_want, cpu_wins, disp_wins, cpu_done_now;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] tmp;

    always @(negedge clk) begin
        if (!RSTn) begin
            chk("reset_outputs", 64'({disp_rdata, disp_rvalid, cpu_ready, cpu_rdata,
                                      ram_en, ram_we, ram_addr, ram_wdata}), 64'd0);
            m_pend = 1'b0; m_pend_addr = '0; m_wait = 0; m_cpu_busy = 1'b0;
            m_cpu_hold = '0; m_stall = 0;
            exp_disp_q.delete(); exp_cpu_q.delete();
        end else begin
            chk("disp_rvalid", 64'(disp_rvalid), 64'(exp_disp_q.size() != 0));
            if (exp_disp_q.size() != 0) begin
                tmp = exp_disp_q.pop_front();
                chk("disp_rdata", 64'(disp_rdata), 64'(tmp));
            end
            cpu_done_now = (exp_cpu_q.size() != 0);
            chk("cpu_ready", 64'(cpu_ready), 64'(cpu_done_now));
            if (cpu_done_now) begin
                m_cpu_hold = exp_cpu_q.pop_front();
                cnt_ready++;
            end
            chk("cpu_rdata", 64'(cpu_rdata), 64'(m_cpu_hold));
            if (ram_en && ram_we) cnt_wr++;

            d_want    = disp_req || m_pend;
            c_want    = cpu_req && !m_cpu_busy;
            cpu_wins  = c_want && (!d_want || m_wait >= SL);
            disp_wins = d_want && !cpu_wins;
            d_addr    = disp_req ? disp_addr : m_pend_addr;

            chk("ram_en", 64'(ram_en), 64'(cpu_wins || disp_wins));
            if (cpu_wins) begin
                chk("ram_we_cpu", 64'(ram_we), 64'(cpu_we));
                chk("ram_addr_cpu", 64'(ram_addr), 64'(cpu_addr));
                if (cpu_we) begin
                    chk("ram_wdata", 64'(ram_wdata), 64'(cpu_wdata));
                    exp_mem[cpu_addr] = cpu_wdata;
                    exp_cpu_q.push_back('0);
                end else begin
                    exp_cpu_q.push_back(exp_mem[cpu_addr]);
                end
            end
            if (disp_wins) begin
                chk("ram_we_disp", 64'(ram_we), 64'd0);
                chk("ram_addr_disp", 64'(ram_addr), 64'(d_addr));
                exp_disp_q.push_back(exp_mem[d_addr]);
            end

`ifdef VRAM_ARB_PERF_EN
            chk("stall_cnt", 64'(cpu_stall_cnt), 64'(m_stall));
            if (perf_clr) m_stall = 0;
            else if (c_want && disp_wins && m_stall < 65535) m_stall++;
`endif

            // A display request that is not served this cycle waits (newest address wins).
            if (disp_wins) m_pend = 1'b0;
            else if (disp_req) begin
                m_pend = 1'b1;
                m_pend_addr = disp_addr;
            end
            if (!c_want || cpu_wins) m_wait = 0;
            else if (m_wait < SL) m_wait++;
            if (cpu_done_now) m_cpu_busy = 1'b0;
            if (cpu_wins) m_cpu_busy = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts at posedge+1, returns at posedge+1 with cpu_req dropped; lat = cycles from request to ready.
    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              output int lat, output logic [DW-1:0] rd);
        int n;
        n = 0;
        rd = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        forever begin
            @(negedge clk);
            n++;
            if (cpu_ready) begin
                rd = cpu_rdata;
                break;
            end
            if (n > 40) begin
                n_cmp++; n_bad++;
                $display("FAIL cpu_ready_timeout: no ready after %0d cycles, required within %0d", n, 40);
                break;
            end
        end
        lat = n - 1;
        step();
        cpu_req = 1'b0;
    endtask

    task automatic disp_pulse(input logic [AW-1:0] a);
        disp_req = 1'b1; disp_addr = a;
        step();
        disp_req = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    int            lat;
    logic [DW-1:0] rd;
    int            n;

    initial begin
        RSTn = 1'b0; disp_req = 1'b0; disp_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
`ifdef VRAM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        mem[12'h010] = 8'h3C; exp_mem[12'h010] = 8'h3C;
        mem[12'h108] = 8'h77; exp_mem[12'h108] = 8'h77;
        mem[12'h030] = 8'h11; exp_mem[12'h030] = 8'h11;
        mem[12'h040] = 8'h42; exp_mem[12'h040] = 8'h42;

        repeat (3) step();
        @(negedge clk);
        chk("reset_ram_en", 64'(ram_en), 64'd0);
        chk("reset_cpu_ready", 64'(cpu_ready), 64'd0);
        step();
        RSTn = 1'b1;
        step();

        // Display-only read
        disp_req = 1'b1; disp_addr = 12'h010;
        @(negedge clk);
        chk("t1_ram_en", 64'(ram_en), 64'd1);
        chk("t1_ram_addr", 64'(ram_addr), 64'h010);
        step();
        disp_req = 1'b0;
        @(negedge clk);
        chk("t1_rvalid", 64'(disp_rvalid), 64'd1);
        chk("t1_rdata", 64'(disp_rdata), 64'h3C);
        step();

        // Uncontended CPU write then read
        cpu_access(1'b1, 12'h7FF, 8'hA5, lat, rd);
        chk("t2_wr_latency", 64'(lat), 64'd1);
        cpu_access(1'b0, 12'h7FF, 8'h00, lat, rd);
        chk("t2_rd_latency", 64'(lat), 64'd1);
        chk("t2_rd_data", 64'(rd), 64'hA5);
        step();

        // Display every cycle: CPU wins once the guard saturates, held display read returns in 2
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    disp_req = 1'b1; disp_addr = AW'(12'h100 + i);
                    step();
                end
                disp_req = 1'b0;
                @(negedge clk);
                chk("t3_held_addr", 64'(ram_addr), 64'h108);
                chk("t3_held_we", 64'(ram_we), 64'd0);
                step();
                @(negedge clk);
                chk("t3_held_rvalid", 64'(disp_rvalid), 64'd1);
                chk("t3_held_rdata", 64'(disp_rdata), 64'h77);
            end
            begin
                cpu_access(1'b1, 12'h020, 8'h5A, lat, rd);
                chk("t3_starve_latency", 64'(lat), 64'(SL + 1));
            end
        join
        step();

        // Display every 2 cycles alongside a CPU write
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    disp_pulse(AW'(12'h200 + i));
                    step();
                end
            end
            begin
                cpu_access(1'b1, 12'h201, 8'hC3, lat, rd);
                chk("t3b_latency", 64'(lat), 64'd2);
                cpu_access(1'b0, 12'h020, 8'h00, lat, rd);
                chk("t3b_rd_data", 64'(rd), 64'h5A);
            end
        join
        repeat (2) step();

        // Same-cycle contention, same address: display sees old data, one write, one ready
        cnt_ready = 0; cnt_wr = 0;
        fork
            begin
                disp_pulse(12'h030);
                @(negedge clk);
                chk("t4_disp_old", 64'(disp_rdata), 64'h11);
            end
            begin
                cpu_access(1'b1, 12'h030, 8'h99, lat, rd);
                chk("t4_cpu_latency", 64'(lat), 64'd2);
            end
        join
        repeat (3) step();
        chk("t4_ready_pulses", 64'(cnt_ready), 64'd1);
        chk("t4_ram_writes", 64'(cnt_wr), 64'd1);
        disp_pulse(12'h030);
        @(negedge clk);
        chk("t4_disp_new", 64'(disp_rdata), 64'h99);
        step();

        // Reset while a CPU read is in flight
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h040;
        @(negedge clk);
        chk("t5_issue", 64'(ram_en), 64'd1);
        step();
        RSTn = 1'b0;
        @(negedge clk);
        chk("t5_no_ready", 64'(cpu_ready), 64'd0);
        chk("t5_cpu_rdata", 64'(cpu_rdata), 64'd0);
        step();
        RSTn = 1'b1;
        cnt_ready = 0;
        n = 0;
        rd = '0;
        forever begin
            @(negedge clk);
            n++;
            if (cpu_ready) begin
                rd = cpu_rdata;
                break;
            end
            if (n > 10) begin
                n_cmp++; n_bad++;
                $display("FAIL t5_timeout: no ready after %0d cycles, required within %0d", n, 10);
                break;
            end
        end
        step();
        cpu_req = 1'b0;
        repeat (3) step();
        chk("t5_ready_once", 64'(cnt_ready), 64'd1);
        chk("t5_rdata", 64'(rd), 64'h42);

`ifdef VRAM_ARB_PERF_EN
        // Stall counter: 5 stalls, clear, then saturation
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    disp_req = 1'b1; disp_addr = AW'(12'h300 + i);
                    step();
                end
                disp_req = 1'b0;
            end
            cpu_access(1'b1, 12'h300, 8'h01, lat, rd);
        join
        @(negedge clk);
        chk("perf_five", 64'(cpu_stall_cnt), 64'd5);
        step();
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        @(negedge clk);
        chk("perf_clear", 64'(cpu_stall_cnt), 64'd0);
        step();
        disp_req = 1'b1; disp_addr = 12'h001;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h002;
        repeat (88000) step();
        @(negedge clk);
        chk("perf_saturate", 64'(cpu_stall_cnt), 64'hFFFF);
        step();
        disp_req = 1'b0;
        cpu_req = 1'b0;
        repeat (3) step();
`endif

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
